// File: rtl/ftdi_fifo_bridge.sv
// FT232H-style 245-FIFO controller: strobed reads framed into packets, writes from a TX FIFO.
// Define FTDI_BRIDGE_SYNC_EN to pass rxf_n/txe_n through 2-flop synchronisers.
module ftdi_fifo_bridge #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PKT_LEN     = 128,
  parameter int unsigned RD_LOW_CYC  = 3,
  parameter int unsigned RD_HIGH_CYC = 2,
  parameter int unsigned WR_LOW_CYC  = 2,
  parameter int unsigned TX_DEPTH    = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          rxf_n,
  input  logic                          txe_n,
  input  logic [DATA_W-1:0]             adbus_in,
  output logic [DATA_W-1:0]             adbus_out,
  output logic                          adbus_oe,
  output logic                          rd_n,
  output logic                          wr_n,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  output logic [$clog2(PKT_LEN)-1:0]    rx_idx,
  output logic                          rx_pkt_done,
  input  logic                          rx_ready,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(TX_DEPTH):0]     tx_count
);

  localparam int unsigned IdxW   = $clog2(PKT_LEN);
  localparam int unsigned PtrW   = $clog2(TX_DEPTH);
  localparam int unsigned CntMax = (RD_LOW_CYC > RD_HIGH_CYC) ?
                                   ((RD_LOW_CYC > WR_LOW_CYC) ? RD_LOW_CYC : WR_LOW_CYC) :
                                   ((RD_HIGH_CYC > WR_LOW_CYC) ? RD_HIGH_CYC : WR_LOW_CYC);
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam logic [PtrW:0] TxFull = (PtrW + 1)'(TX_DEPTH);

  typedef enum logic [2:0] {
    StIdle, StRdLow, StRdHigh, StWrSetup, StWrLow, StWrHigh
  } state_e;

  logic rxf_n_s, txe_n_s;

`ifdef FTDI_BRIDGE_SYNC_EN
  logic [1:0] rxf_sync_q, txe_sync_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxf_sync_q <= 2'b11;
      txe_sync_q <= 2'b11;
    end else begin
      rxf_sync_q <= {rxf_sync_q[0], rxf_n};
      txe_sync_q <= {txe_sync_q[0], txe_n};
    end
  end
  assign rxf_n_s = rxf_sync_q[1];
  assign txe_n_s = txe_sync_q[1];
`else
  assign rxf_n_s = rxf_n;
  assign txe_n_s = txe_n;
`endif

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                rd_prio_q, rd_prio_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [IdxW-1:0]     rx_idx_q, rx_idx_d;
  logic                rx_done_q, rx_done_d;
  logic [IdxW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [DATA_W-1:0]   adbus_out_q, adbus_out_d;
  logic [PtrW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_W-1:0]   mem_q [TX_DEPTH];
  logic                push, pop, rd_req, wr_req;
  logic [DATA_W-1:0]   head;

  assign tx_count = wptr_q - rptr_q;
  // A pop in this cycle frees a slot, so a full FIFO can still take a push.
  assign tx_ready = (tx_count != TxFull) || pop;
  assign push     = tx_valid && tx_ready;
  assign head     = mem_q[rptr_q[PtrW-1:0]];
  assign rd_req   = !rxf_n_s && rx_ready;
  assign wr_req   = !txe_n_s && (tx_count != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_prio_d   = rd_prio_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_idx_d    = rx_idx_q;
    rx_done_d   = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    adbus_out_d = adbus_out_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rd_req && (!wr_req || rd_prio_q)) begin
          state_d   = StRdLow;
          rd_prio_d = 1'b0;
        end else if (wr_req) begin
          state_d     = StWrSetup;
          rd_prio_d   = 1'b1;
          adbus_out_d = head;
        end
      end
      StRdLow: begin
        if (cnt_q == CntW'(RD_LOW_CYC - 1)) begin
          cnt_d      = '0;
          state_d    = StRdHigh;
          rx_data_d  = adbus_in;
          rx_valid_d = 1'b1;
          rx_idx_d   = pkt_cnt_q;
          rx_done_d  = (pkt_cnt_q == IdxW'(PKT_LEN - 1));
          pkt_cnt_d  = rx_done_d ? '0 : pkt_cnt_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdHigh: begin
        if (cnt_q == CntW'(RD_HIGH_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrSetup: begin
        cnt_d   = '0;
        state_d = StWrLow;
      end
      StWrLow: begin
        if (cnt_q == CntW'(WR_LOW_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StWrHigh;
          pop     = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrHigh: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d = push ? wptr_q + (PtrW + 1)'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + (PtrW + 1)'(1) : rptr_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_prio_q   <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_idx_q    <= '0;
      rx_done_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      adbus_out_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_prio_q   <= rd_prio_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_idx_q    <= rx_idx_d;
      rx_done_q   <= rx_done_d;
      pkt_cnt_q   <= pkt_cnt_d;
      adbus_out_q <= adbus_out_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q[PtrW-1:0]] <= tx_data;
  end

  // Strobes and OE decode straight from state so an async reset clears them immediately.
  assign rd_n        = (state_q != StRdLow);
  assign wr_n        = (state_q != StWrLow);
  assign adbus_oe    = (state_q == StWrSetup) || (state_q == StWrLow) || (state_q == StWrHigh);
  assign adbus_out   = adbus_out_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_idx      = rx_idx_q;
  assign rx_pkt_done = rx_done_q;

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Bench for ftdi_fifo_bridge: FTDI chip model feeds expectation queues, a bus monitor checks them.
`timescale 1ns/1ps
module tb_ftdi_fifo_bridge;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned PKT_LEN     = 128;
  localparam int unsigned RD_LOW_CYC  = 3;
  localparam int unsigned RD_HIGH_CYC = 2;
  localparam int unsigned WR_LOW_CYC  = 2;
  localparam int unsigned TX_DEPTH    = 16;
  localparam int unsigned IDX_W       = $clog2(PKT_LEN);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
  } rx_exp_t;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  rxf_n = 1'b1;
  logic                  txe_n = 1'b1;
  logic [DATA_W-1:0]     adbus_in = '0;
  logic [DATA_W-1:0]     adbus_out;
  logic                  adbus_oe, rd_n, wr_n;
  logic [DATA_W-1:0]     rx_data;
  logic                  rx_valid, rx_pkt_done;
  logic [IDX_W-1:0]      rx_idx;
  logic                  rx_ready = 1'b1;
  logic [DATA_W-1:0]     tx_data = '0;
  logic                  tx_valid = 1'b0;
  logic                  tx_ready;
  logic [$clog2(TX_DEPTH):0] tx_count;

  always #5 clock = ~clock;

  ftdi_fifo_bridge #(
    .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .RD_LOW_CYC(RD_LOW_CYC),
    .RD_HIGH_CYC(RD_HIGH_CYC), .WR_LOW_CYC(WR_LOW_CYC), .TX_DEPTH(TX_DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rxf_n(rxf_n), .txe_n(txe_n),
    .adbus_in(adbus_in), .adbus_out(adbus_out), .adbus_oe(adbus_oe),
    .rd_n(rd_n), .wr_n(wr_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_idx(rx_idx), .rx_pkt_done(rx_pkt_done), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_count(tx_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Scoreboard state
  logic [DATA_W-1:0] ftdi_q[$];
  rx_exp_t           exp_rx[$];
  logic [DATA_W-1:0] exp_tx[$];
  int unsigned       exp_idx = 0;
  int unsigned       pushed_total = 0;
  bit                mon_en = 1'b0;

  // FTDI chip: presents the next byte when rd_n falls; rxf_n goes high during the
  // second low cycle of the read that empties its queue.
  logic        ftdi_rd_prev = 1'b1;
  int unsigned ftdi_low = 0;
  always @(negedge clock) begin
    if (ftdi_rd_prev && !rd_n) begin
      chk("rd_has_data", 32'(ftdi_q.size() != 0), 1);
      if (ftdi_q.size() != 0) adbus_in = ftdi_q.pop_front();
      else adbus_in = DATA_W'($urandom);
      exp_rx.push_back('{data: adbus_in, idx: exp_idx[IDX_W-1:0]});
      exp_idx  = (exp_idx + 1) % PKT_LEN;
      ftdi_low = 1;
    end else if (!rd_n) begin
      ftdi_low++;
    end
    ftdi_rd_prev = rd_n;
    rxf_n = (ftdi_q.size() == 0) && (rd_n || ftdi_low >= 2);
  end

  // Monitor
  logic        mon_rd_prev = 1'b1, mon_wr_prev = 1'b1, mon_oe_prev = 1'b0;
  int unsigned rd_run = 0, wr_run = 0, oe_run = 0;
  int unsigned rx_seen = 0, wr_seen = 0, rd_falls = 0, done_seen = 0;
  bit          strobe_log[$];
  rx_exp_t     mon_e;
  always @(negedge clock) begin
    if (mon_en) begin
      if (!rd_n) begin
        chk("rd_oe_overlap", 32'(adbus_oe), 0);
        rd_run++;
        if (mon_rd_prev) begin
          chk("rd_turnaround", 32'(mon_oe_prev), 0);
          strobe_log.push_back(1'b0);
          rd_falls++;
        end
      end else begin
        if (!mon_rd_prev) chk("rd_low_width", rd_run, RD_LOW_CYC);
        rd_run = 0;
      end
      if (!wr_n) begin
        wr_run++;
        chk("wr_oe", 32'(adbus_oe), 1);
        chk("wr_expected_present", 32'(exp_tx.size() != 0), 1);
        if (exp_tx.size() != 0) chk("wr_data", 32'(adbus_out), 32'(exp_tx[0]));
        if (mon_wr_prev) strobe_log.push_back(1'b1);
      end else begin
        if (!mon_wr_prev) begin
          chk("wr_low_width", wr_run, WR_LOW_CYC);
          if (exp_tx.size() != 0) void'(exp_tx.pop_front());
          wr_seen++;
        end
        wr_run = 0;
      end
      if (adbus_oe) oe_run++;
      else begin
        if (mon_oe_prev) chk("oe_width", oe_run, WR_LOW_CYC + 2);
        oe_run = 0;
      end
      if (rx_valid) begin
        chk("rx_expected_present", 32'(exp_rx.size() != 0), 1);
        if (exp_rx.size() != 0) begin
          mon_e = exp_rx.pop_front();
          chk("rx_data", 32'(rx_data), 32'(mon_e.data));
          chk("rx_idx", 32'(rx_idx), 32'(mon_e.idx));
          chk("rx_pkt_done", 32'(rx_pkt_done), 32'(mon_e.idx == IDX_W'(PKT_LEN - 1)));
        end
        rx_seen++;
        if (rx_pkt_done) done_seen++;
      end
    end else begin
      rd_run = 0;
      wr_run = 0;
      oe_run = 0;
    end
    mon_rd_prev = rd_n;
    mon_wr_prev = wr_n;
    mon_oe_prev = adbus_oe;
  end

  task automatic push_tx(input logic [DATA_W-1:0] d, input bit accept);
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = d;
    if (accept) begin
      exp_tx.push_back(d);
      pushed_total++;
    end
    @(posedge clock);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_rx_drain(input string name, input int bound);
    for (int i = 0; i < bound && (ftdi_q.size() != 0 || exp_rx.size() != 0); i++)
      @(negedge clock);
    chk(name, 32'(ftdi_q.size() + exp_rx.size()), 0);
  endtask

  task automatic wait_tx_drain(input string name, input int bound);
    for (int i = 0; i < bound && exp_tx.size() != 0; i++) @(negedge clock);
    chk(name, 32'(exp_tx.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    int unsigned base, base_done, base_wr;
    // Reset values
    repeat (3) @(negedge clock);
    chk("reset_rd_n", 32'(rd_n), 1);
    chk("reset_wr_n", 32'(wr_n), 1);
    chk("reset_oe", 32'(adbus_oe), 0);
    chk("reset_adbus_out", 32'(adbus_out), 0);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_rx_idx", 32'(rx_idx), 0);
    chk("reset_tx_count", 32'(tx_count), 0);
    chk("reset_tx_ready", 32'(tx_ready), 1);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // One full packet of bytes 1..128
    base_done = done_seen;
    base = rx_seen;
    for (int i = 1; i <= 128; i++) ftdi_q.push_back(DATA_W'(i));
    wait_rx_drain("pkt_drain", 2000);
    repeat (10) @(negedge clock);
    chk("pkt_rx_count", rx_seen - base, 128);
    chk("pkt_done_count", done_seen - base_done, 1);

    // Async reset in the middle of RD_LOW
    for (int i = 0; i < 3; i++) ftdi_q.push_back(DATA_W'(8'h50 + i));
    for (int i = 0; i < 20 && rd_n; i++) @(negedge clock);
    chk("rd_started_before_reset", 32'(rd_n), 0);
    @(posedge clock);
    #2 mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midread_reset_rd_n", 32'(rd_n), 1);
    chk("midread_reset_oe", 32'(adbus_oe), 0);
    chk("midread_reset_rx_valid", 32'(rx_valid), 0);
    repeat (2) @(negedge clock);
    exp_rx.delete();
    exp_idx = 0;
    reset_n = 1'b1;
    #1;
    chk("post_reset_rx_idx", 32'(rx_idx), 0);
    chk("post_reset_rx_valid", 32'(rx_valid), 0);
    mon_en = 1'b1;
    wait_rx_drain("post_reset_drain", 100);

    // Fill TX FIFO with the chip refusing writes
    txe_n = 1'b1;
    for (int i = 0; i < 16; i++) push_tx(DATA_W'(8'hA0 + i), 1'b1);
    @(negedge clock);
    chk("tx_count_full", 32'(tx_count), 16);
    chk("tx_ready_full", 32'(tx_ready), 0);
    push_tx(DATA_W'(8'hEE), 1'b0);
    @(negedge clock);
    chk("tx_count_after_overflow", 32'(tx_count), 16);
    base_wr = wr_seen;
    txe_n = 1'b0;
    wait_tx_drain("tx_drain", 400);
    repeat (4) @(negedge clock);
    chk("tx_write_count", wr_seen - base_wr, 16);
    chk("tx_count_empty", 32'(tx_count), 0);
    chk("tx_ready_empty", 32'(tx_ready), 1);

    // Read/write arbitration with both sides requesting
    txe_n = 1'b1;
    for (int i = 0; i < 4; i++) push_tx(DATA_W'($urandom), 1'b1);
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) ftdi_q.push_back(DATA_W'($urandom));
    strobe_log.delete();
    @(negedge clock);
    #1 txe_n = 1'b0;
    wait_tx_drain("arb_tx_drain", 300);
    wait_rx_drain("arb_rx_drain", 300);
    chk("arb_strobe_count", 32'(strobe_log.size()), 12);
    for (int i = 1; i < 8 && i < strobe_log.size(); i++)
      chk("arb_alternate", 32'(strobe_log[i] != strobe_log[i-1]), 1);

    // rx_ready gating
    rx_ready = 1'b0;
    ftdi_q.push_back(DATA_W'($urandom));
    ftdi_q.push_back(DATA_W'($urandom));
    base = rd_falls;
    repeat (10) @(negedge clock);
    chk("rd_blocked_by_rx_ready", rd_falls - base, 0);
    chk("rd_n_idle_while_blocked", 32'(rd_n), 1);
    rx_ready = 1'b1;
    @(negedge clock);
    #1 chk("rd_start_after_ready", 32'(rd_n), 0);
    rx_ready = 1'b0;
    repeat (10) @(negedge clock);
    chk("one_read_while_not_ready", rd_falls - base, 1);
    rx_ready = 1'b1;
    wait_rx_drain("ready_drain", 100);
    base = rd_falls;
    repeat (10) @(negedge clock);
    chk("no_reread_after_rxf_rise", rd_falls - base, 0);

    // Randomised mixed traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      txe_n    = ($urandom_range(3) == 0);
      rx_ready = ($urandom_range(4) != 0);
      if ($urandom_range(5) == 0 && ftdi_q.size() < 4) ftdi_q.push_back(DATA_W'($urandom));
      if ($urandom_range(2) == 0 && (pushed_total - wr_seen) < TX_DEPTH) begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'($urandom);
        exp_tx.push_back(tx_data);
        pushed_total++;
      end else begin
        tx_valid = 1'b0;
      end
    end
    @(negedge clock);
    tx_valid = 1'b0;
    txe_n    = 1'b0;
    rx_ready = 1'b1;
    wait_tx_drain("rand_tx_drain", 1000);
    wait_rx_drain("rand_rx_drain", 1000);
    repeat (10) @(negedge clock);
    chk("final_tx_count", 32'(tx_count), 0);
    chk("final_tx_pushes_written", wr_seen, pushed_total);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
